// File: rtl/mpu_pkg.sv
// Shared MPU definitions: matrix geometry, load-phase encoding and the flat-bus index helper.
// No ports; imported by the loader and reusable by the other MPU stages.
package mpu_pkg;

  localparam int unsigned MPU_DIM   = 5;
  localparam int unsigned MPU_WIDTH = 8;
  localparam int unsigned MPU_ELEMS = MPU_DIM * MPU_DIM;

  // Encoding is visible on load_phase, so the values are fixed.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } load_phase_t;

  // LSB of element (i,j) on a row-major flattened matrix bus.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j);
    return (i * MPU_DIM + j) * MPU_WIDTH;
  endfunction

endpackage

// File: rtl/mpu_matrix_loader_if.sv
// Loader bus: byte-stream input (in_valid/in_ready/in_data) and the matrix-pair output
// (out_valid/out_ready/matrix_a/matrix_b).
//  master : stream source and pair consumer (drives in_valid, in_data, out_ready)
//  slave  : the loader (drives in_ready, out_valid, matrix_a, matrix_b)
interface mpu_matrix_loader_if #(
  parameter int unsigned DIM   = mpu_pkg::MPU_DIM,
  parameter int unsigned WIDTH = mpu_pkg::MPU_WIDTH
);

  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DIM*DIM*WIDTH-1:0]   matrix_a;
  logic [DIM*DIM*WIDTH-1:0]   matrix_b;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, matrix_a, matrix_b
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, matrix_a, matrix_b
  );

endinterface

// File: rtl/mpu_index_counter.sv
// Modulo-Count element counter.
//  clock, reset : rising-edge clock, asynchronous active-high reset
//  en           : advance by one (wraps Count-1 -> 0)
//  clr          : synchronous clear to 0, wins over en
//  idx          : current index
//  wrap         : high in the cycle an enabled count leaves Count-1
module mpu_index_counter #(
  parameter int unsigned Count = mpu_pkg::MPU_ELEMS,
  parameter int unsigned IdxW  = (Count > 1) ? $clog2(Count) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  output logic [IdxW-1:0] idx,
  output logic            wrap
);

  logic [IdxW-1:0] idx_q, idx_d;
  logic            last;

  assign last = (idx_q == IdxW'(Count - 1));
  assign wrap = en & last;
  assign idx  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/mpu_matrix_loader.sv
// MPU input stage: assembles matrix A then matrix B (row-major) from a byte stream and holds
// the pair stable on flat buses with a valid/ready handshake. The stream is back-pressured
// while a complete pair waits to be consumed.
//  clock, reset : rising-edge clock, asynchronous active-high reset
//  abort        : synchronous restart of the load (matrix contents kept)
//  bus          : stream in / matrix pair out (slave side)
//  load_phase   : 0=LOAD_A 1=LOAD_B 2=FULL
module mpu_matrix_loader
  import mpu_pkg::*;
#(
  parameter int unsigned DIM   = MPU_DIM,
  parameter int unsigned WIDTH = MPU_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 abort,
  mpu_matrix_loader_if.slave   bus,
  output logic [1:0]           load_phase
);

  localparam int unsigned Elems = DIM * DIM;
  localparam int unsigned IdxW  = $clog2(Elems);

  load_phase_t            state_q, state_d;
  logic                   accept;
  logic                   wrap;
  logic [IdxW-1:0]        idx;
  logic [Elems-1:0]       sel;
  logic [WIDTH-1:0]       a_q [Elems];
  logic [WIDTH-1:0]       b_q [Elems];
  logic [Elems*WIDTH-1:0] a_flat, b_flat;

  // Handshake flags come straight from the registered state.
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q == FULL);
  assign accept        = bus.in_valid & bus.in_ready & ~abort;
  assign load_phase    = state_q;

  mpu_index_counter #(
    .Count (Elems),
    .IdxW  (IdxW)
  ) u_idx (
    .clock (clock),
    .reset (reset),
    .en    (accept),
    .clr   (abort),
    .idx   (idx),
    .wrap  (wrap)
  );

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = LOAD_A;
    end else begin
      unique case (state_q)
        LOAD_A:  if (wrap) state_d = LOAD_B;
        LOAD_B:  if (wrap) state_d = FULL;
        FULL:    if (bus.out_ready) state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    sel = '0;
    for (int k = 0; k < Elems; k++) begin
      sel[k] = (idx == IdxW'(k));
    end
  end

  // Accept never happens in FULL, so LOAD_A vs. otherwise picks the bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < Elems; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < Elems; k++) begin
        if (accept && sel[k]) begin
          if (state_q == LOAD_A) begin
            a_q[k] <= bus.in_data;
          end else begin
            b_q[k] <= bus.in_data;
          end
        end
      end
    end
  end

  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int k = 0; k < Elems; k++) begin
      a_flat[k*WIDTH +: WIDTH] = a_q[k];
      b_flat[k*WIDTH +: WIDTH] = b_q[k];
    end
  end

  assign bus.matrix_a = a_flat;
  assign bus.matrix_b = b_flat;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
module tb_mpu_matrix_loader;
  import mpu_pkg::*;

  localparam int unsigned MW = MPU_ELEMS * MPU_WIDTH;

  logic clock;
  logic reset;
  logic abort;
  logic [1:0] load_phase;

  int n_checks = 0;
  int n_fail   = 0;
  int accept_cnt = 0;
  int base_cnt;

  logic [MW-1:0] exp_a, exp_b;

  mpu_matrix_loader_if #(.DIM(MPU_DIM), .WIDTH(MPU_WIDTH)) bus ();

  mpu_matrix_loader #(
    .DIM   (MPU_DIM),
    .WIDTH (MPU_WIDTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .abort      (abort),
    .bus        (bus),
    .load_phase (load_phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent count of stream transfers that should land in the banks.
  always @(posedge clock) begin
    if (!reset && bus.in_valid && bus.in_ready && !abort) accept_cnt <= accept_cnt + 1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one element (called at a negedge); returns at the negedge after its accept.
  task automatic send(input logic [7:0] d, input int gaps);
    bit done;
    if (gaps > 0) begin
      bus.in_valid = 1'b0;
      repeat (gaps) @(negedge clock);
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (bus.in_ready) done = 1'b1;
      @(negedge clock);
    end
    check("send_timeout", 256'(done), 256'(1'b1));
  endtask

  function automatic logic [MW-1:0] build(input int base);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < MPU_DIM; i++)
      for (int j = 0; j < MPU_DIM; j++)
        m[elem_lsb(i, j) +: MPU_WIDTH] = 8'(base + i * MPU_DIM + j);
    return m;
  endfunction

  task automatic check_full(input string tag);
    check({tag, "_out_valid"}, 256'(bus.out_valid), 256'(1'b1));
    check({tag, "_in_ready"},  256'(bus.in_ready),  256'(1'b0));
    check({tag, "_phase"},     256'(load_phase),    256'(2'd2));
    check({tag, "_matrix_a"},  256'(bus.matrix_a),  256'(exp_a));
    check({tag, "_matrix_b"},  256'(bus.matrix_b),  256'(exp_b));
  endtask

  task automatic consume();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    abort = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_matrix_a",  256'(bus.matrix_a),  256'(0));
    check("rst_matrix_b",  256'(bus.matrix_b),  256'(0));
    check("rst_out_valid", 256'(bus.out_valid), 256'(1'b0));
    check("rst_phase",     256'(load_phase),    256'(2'd0));
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready",  256'(bus.in_ready),  256'(1'b1));

    // Test 1: back-to-back load of 1..25 then 101..125
    exp_a = build(1);
    exp_b = build(101);
    base_cnt = accept_cnt;
    for (int k = 0; k < 25; k++) send(8'(1 + k), 0);
    check("t1_phase_after_a", 256'(load_phase), 256'(2'd1));
    for (int k = 0; k < 25; k++) send(8'(101 + k), 0);
    check_full("t1");
    check("t1_a00", 256'(bus.matrix_a[elem_lsb(0, 0) +: 8]), 256'(8'd1));
    check("t1_a44", 256'(bus.matrix_a[elem_lsb(4, 4) +: 8]), 256'(8'd25));
    check("t1_b23", 256'(bus.matrix_b[elem_lsb(2, 3) +: 8]), 256'(8'd114));
    check("t1_accepts", 256'(accept_cnt - base_cnt), 256'(50));

    // Test 6: in FULL, hold in_valid with 0xFF; everything stays frozen for 10 cycles
    bus.in_data  = 8'hFF;
    bus.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check_full("t6_hold");
    end
    check("t6_accepts", 256'(accept_cnt - base_cnt), 256'(50));

    // Test 2: one-cycle out_ready releases the pair
    consume();
    check("t2_out_valid", 256'(bus.out_valid), 256'(1'b0));
    check("t2_in_ready",  256'(bus.in_ready),  256'(1'b1));
    check("t2_phase",     256'(load_phase),    256'(2'd0));
    check("t2_a_kept",    256'(bus.matrix_a),  256'(exp_a));

    // Test 3: same data with random idle gaps
    base_cnt = accept_cnt;
    for (int k = 0; k < 25; k++) send(8'(1 + k), int'($urandom_range(0, 1)));
    for (int k = 0; k < 25; k++) send(8'(101 + k), int'($urandom_range(0, 1)));
    bus.in_valid = 1'b0;
    @(negedge clock);
    check_full("t3");
    check("t3_accepts", 256'(accept_cnt - base_cnt), 256'(50));
    consume();

    // Test 4: abort in LOAD_B at idx=5, then a fresh pair; out_ready held early is ignored
    base_cnt = accept_cnt;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 30; k++) send(8'(60 + k), 0);
    check("t4_phase_pre", 256'(load_phase), 256'(2'd1));
    abort        = 1'b1;
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    @(negedge clock);
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("t4_phase_abort", 256'(load_phase),   256'(2'd0));
    check("t4_in_ready",    256'(bus.in_ready), 256'(1'b1));
    check("t4_b5_kept", 256'(bus.matrix_b[elem_lsb(1, 0) +: 8]), 256'(8'd106));
    exp_a = build(31);
    exp_b = build(201);
    for (int k = 0; k < 25; k++) send(8'(31 + k), 0);
    for (int k = 0; k < 25; k++) send(8'(201 + k), 0);
    bus.in_valid = 1'b0;
    check_full("t4");
    check("t4_accepts", 256'(accept_cnt - base_cnt), 256'(80));
    consume();

    // Test 5: asynchronous reset mid-LOAD_B, checked before any clock edge
    for (int k = 0; k < 28; k++) send(8'(10 + k), 0);
    check("t5_phase_pre", 256'(load_phase), 256'(2'd1));
    #2 reset = 1'b1;
    #1;
    check("t5_matrix_a",  256'(bus.matrix_a),  256'(0));
    check("t5_matrix_b",  256'(bus.matrix_b),  256'(0));
    check("t5_out_valid", 256'(bus.out_valid), 256'(1'b0));
    check("t5_phase",     256'(load_phase),    256'(2'd0));
    check("t5_in_ready",  256'(bus.in_ready),  256'(1'b1));
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
